// File: rtl/soc_system_vga_pixel_writer.sv
// rtl/soc_system_vga_pixel_writer.sv - turns PIO write-enable edges into single Avalon-MM framebuffer writes
module soc_system_vga_pixel_writer #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clr_status,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_write,
    input  logic              mem_waitrequest,
    output logic              busy,
    output logic [15:0]       write_count,
    output logic              overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t state;
    logic   we_d;
    logic   rise;

    // we_d resets high so an enable already asserted at reset release is not a write
    assign rise = we_in & ~we_d;
    assign busy = (state == WRITE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            we_d          <= 1'b1;
            mem_address   <= '0;
            mem_writedata <= '0;
            mem_write     <= 1'b0;
            write_count   <= 16'd0;
            overrun       <= 1'b0;
        end else begin
            we_d <= we_in;
            if (state == IDLE) begin
                if (rise) begin
                    mem_address   <= addr_in;
                    mem_writedata <= data_in;
                    mem_write     <= 1'b1;
                    state         <= WRITE;
                end
            end else begin
                if (!mem_waitrequest) begin
                    mem_write   <= 1'b0;
                    write_count <= write_count + 16'd1;
                    state       <= IDLE;
                end
                // an edge arriving while a write is outstanding is dropped
                if (rise) begin
                    overrun <= 1'b1;
                end
            end
            if (clr_status) begin
                write_count <= 16'd0;
                overrun     <= 1'b0;
            end
        end
    end

endmodule
